// File: rtl/gate_sweep_pkg.sv
// Shared constants and types for the AND-gate sweep controller.
package gate_sweep_pkg;

    // Sweep geometry: 16 vectors of 4 bits, error count must reach 16.
    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;

    // Width of the settle wait counter (covers SETTLE up to 15).
    localparam int SET_W   = 4;

    // FSM state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_DRIVE  = 3'd1;
    localparam state_t ST_SETTLE = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    // The three responses of the gate under test, grouped for comparison.
    typedef struct packed {
        logic e;
        logic f;
        logic g;
    } gate_resp_t;

endpackage

// File: rtl/gate_expect.sv
// Reference model of the 4-input AND gate: expected responses for a vector.
module gate_expect
    import gate_sweep_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    output logic             exp_e,
    output logic             exp_f,
    output logic             exp_g
);

    // Partial ANDs on each input pair, and the full AND of all four bits.
    always_comb begin
        exp_e = vec[3] & vec[2];
        exp_f = vec[1] & vec[0];
        exp_g = &vec;
    end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all 16 input vectors through a 4-input AND gate, waits SETTLE
// cycles per vector, compares the three responses and logs the errors.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             ina,
    output logic             inb,
    output logic             inc,
    output logic             ind,
    input  logic             oute,
    input  logic             outf,
    input  logic             outg,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [VEC_W-1:0] first_err_vec,
    output logic             pass
);

    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t           state;
    state_t           nstate;
    logic [VEC_W-1:0] vec;
    logic [SET_W-1:0] wait_cnt;
    logic [VEC_W-1:0] stim;
    logic             exp_e;
    logic             exp_f;
    logic             exp_g;
    gate_resp_t       obs_resp;
    gate_resp_t       exp_resp;
    logic             mismatch;

    // Error counter increment that never overflows past a full sweep.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] cnt);
        if (cnt >= ERR_W'(NUM_VEC)) begin
            return cnt;
        end
        return cnt + ERR_W'(1);
    endfunction

    gate_expect u_expect (
        .vec   (vec),
        .exp_e (exp_e),
        .exp_f (exp_f),
        .exp_g (exp_g)
    );

    assign ina = stim[3];
    assign inb = stim[2];
    assign inc = stim[1];
    assign ind = stim[0];

    // One mismatch flag per vector, however many of the three bits differ.
    always_comb begin
        obs_resp = '{e: oute, f: outf, g: outg};
        exp_resp = '{e: exp_e, f: exp_f, g: exp_g};
        mismatch = (obs_resp != exp_resp);
    end

    // Next-state logic of the sweep FSM.
    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:   if (start) nstate = ST_DRIVE;
            ST_DRIVE:  nstate = ST_SETTLE;
            ST_SETTLE: if (wait_cnt <= SET_W'(1)) nstate = ST_CHECK;
            ST_CHECK:  nstate = (vec == LAST_VEC) ? ST_DONE : ST_DRIVE;
            ST_DONE:   nstate = ST_IDLE;
            default:   nstate = ST_IDLE;
        endcase
    end

    // State, counters, stimulus and result registers. The stimulus is loaded
    // on entry to DRIVE so the vector is already on the gate during DRIVE and
    // stays there through SETTLE and CHECK. done and pass are loaded by the
    // edge that closes the DONE cycle, so the pulse lands in the IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            vec           <= '0;
            wait_cnt      <= '0;
            stim          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            pass          <= 1'b0;
        end else begin
            state <= nstate;
            busy  <= (nstate != ST_IDLE);
            done  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec           <= '0;
                        stim          <= '0;
                        err_cnt       <= '0;
                        first_err_vld <= 1'b0;
                        first_err_vec <= '0;
                        pass          <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    wait_cnt <= SETTLE_INIT;
                end
                ST_SETTLE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        err_cnt <= sat_inc(err_cnt);
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_vec <= vec;
                        end
                    end
                    if (vec == LAST_VEC) begin
                        stim <= '0;
                    end else begin
                        vec  <= vec + VEC_W'(1);
                        stim <= vec + VEC_W'(1);
                    end
                end
                ST_DONE: begin
                    pass <= (err_cnt == '0);
                    stim <= '0;
                end
                default: begin
                    stim <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: one instance at SETTLE=2 with a
// fault-injectable gate model, one at SETTLE=1 with a correct gate.
module tb_gate_sweep_ctrl;

    logic       clk;
    logic       rst2_n, rst1_n;
    logic       start2, start1;
    int         fault;

    logic       ina2, inb2, inc2, ind2, oute2, outf2, outg2;
    logic       busy2, done2, vld2, pass2;
    logic [4:0] err2;
    logic [3:0] fev2;

    logic       ina1, inb1, inc1, ind1, oute1, outf1, outg1;
    logic       busy1, done1, vld1, pass1;
    logic [4:0] err1;
    logic [3:0] fev1;

    int tests = 0;
    int fails = 0;
    int n;
    int cnt;

    // Gate under test for the SETTLE=2 instance: 0 good, 1 outg stuck-0, 2 outf stuck-1.
    assign oute2 = ina2 & inb2;
    assign outf2 = (fault == 2) ? 1'b1 : (inc2 & ind2);
    assign outg2 = (fault == 1) ? 1'b0 : (ina2 & inb2 & inc2 & ind2);

    assign oute1 = ina1 & inb1;
    assign outf1 = inc1 & ind1;
    assign outg1 = ina1 & inb1 & inc1 & ind1;

    gate_sweep_ctrl #(.SETTLE(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start2),
        .ina(ina2), .inb(inb2), .inc(inc2), .ind(ind2),
        .oute(oute2), .outf(outf2), .outg(outg2),
        .busy(busy2), .done(done2), .err_cnt(err2),
        .first_err_vld(vld2), .first_err_vec(fev2), .pass(pass2)
    );

    gate_sweep_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .start(start1),
        .ina(ina1), .inb(inb1), .inc(inc1), .ind(ind1),
        .oute(oute1), .outf(outf1), .outg(outg1),
        .busy(busy1), .done(done1), .err_cnt(err1),
        .first_err_vld(vld1), .first_err_vec(fev1), .pass(pass1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done2 is seen high, giving up after limit edges.
    task automatic wait_done2(input int limit, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!done2 && cycles < limit);
    endtask

    function automatic logic [16:0] outs2();
        return {ina2, inb2, inc2, ind2, busy2, done2, err2, vld2, fev2, pass2};
    endfunction

    function automatic logic [16:0] outs1();
        return {ina1, inb1, inc1, ind1, busy1, done1, err1, vld1, fev1, pass1};
    endfunction

    initial begin
        rst2_n = 1'b0;
        rst1_n = 1'b0;
        start2 = 1'b0;
        start1 = 1'b0;
        fault  = 0;
        repeat (3) tick();
        chk("reset_outs2", 32'(outs2()), 32'h0);
        chk("reset_outs1", 32'(outs1()), 32'h0);

        // Correct gate, start on the very first edge after reset release.
        rst2_n = 1'b1;
        rst1_n = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("first_accept_busy", 32'(busy2), 32'h1);
        wait_done2(200, n);
        chk("good_cycles", n, 65);
        chk("good_err", 32'(err2), 32'd0);
        chk("good_pass", 32'(pass2), 32'h1);
        chk("good_vld", 32'(vld2), 32'h0);
        chk("good_busy_at_done", 32'(busy2), 32'h0);
        tick();
        chk("done_single", 32'(done2), 32'h0);
        repeat (5) tick();
        chk("hold_pass", 32'(pass2), 32'h1);
        chk("idle_stim", 32'({ina2, inb2, inc2, ind2}), 32'h0);

        // outg stuck-at-0: only vector 15 fails.
        fault  = 1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("acc_clears_pass", 32'(pass2), 32'h0);
        wait_done2(200, n);
        chk("sa0_cycles", n, 65);
        chk("sa0_err", 32'(err2), 32'd1);
        chk("sa0_vld", 32'(vld2), 32'h1);
        chk("sa0_fev", 32'(fev2), 32'd15);
        chk("sa0_pass", 32'(pass2), 32'h0);

        // outf stuck-at-1: fails wherever c&d is 0, 12 vectors, first is 0.
        fault  = 2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        chk("acc_clears_err", 32'(err2), 32'd0);
        wait_done2(200, n);
        chk("sa1_err", 32'(err2), 32'd12);
        chk("sa1_fev", 32'(fev2), 32'd0);
        chk("sa1_vld", 32'(vld2), 32'h1);
        chk("sa1_pass", 32'(pass2), 32'h0);
        repeat (4) tick();
        chk("hold_err", 32'(err2), 32'd12);

        // Second start pulse during vector 5 must be ignored.
        fault  = 0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (21) tick();
        chk("vec5_stim", 32'({ina2, inb2, inc2, ind2}), 32'd5);
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done2(200, n);
        chk("poke_cycles", n, 65 - 22);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done2) cnt++;
        end
        chk("poke_extra_done", cnt, 0);
        chk("poke_busy", 32'(busy2), 32'h0);

        // start held high: back-to-back sweeps, done pulses 66 cycles apart.
        start2 = 1'b1;
        tick();
        wait_done2(200, n);
        chk("held_first", n, 65);
        wait_done2(200, n);
        chk("held_period", n, 66);
        start2 = 1'b0;
        tick();
        chk("held_stop_busy", 32'(busy2), 32'h0);

        // Asynchronous reset in the middle of vector 7, then a clean sweep.
        fault  = 2;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (30) tick();
        chk("vec7_stim", 32'({ina2, inb2, inc2, ind2}), 32'd7);
        #3;
        rst2_n = 1'b0;
        #1;
        chk("async_rst_outs", 32'(outs2()), 32'h0);
        tick();
        chk("rst_hold_outs", 32'(outs2()), 32'h0);
        fault  = 0;
        rst2_n = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        wait_done2(200, n);
        chk("post_rst_cycles", n, 65);
        chk("post_rst_err", 32'(err2), 32'd0);
        chk("post_rst_pass", 32'(pass2), 32'h1);

        // SETTLE=1: each vector held 3 cycles in order, done 49 cycles after accept.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k < 48; k++) begin
            chk($sformatf("walk_%0d", k), 32'({ina1, inb1, inc1, ind1}), 32'(k / 3));
            tick();
        end
        chk("s1_done_early", 32'(done1), 32'h0);
        tick();
        chk("s1_done_49", 32'(done1), 32'h1);
        chk("s1_err", 32'(err1), 32'd0);
        chk("s1_pass", 32'(pass1), 32'h1);
        chk("s1_stim_zero", 32'({ina1, inb1, inc1, ind1}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
